// File: rtl/spi_slave_if.sv
// Host-side register/FIFO bus of the SPI target: transmit word load, received word strobe, busy flag.
// Latency: pure wiring, no storage; all timing lives in the spi_slave module.
// Backpressure: none; RxData/RxValid is a fire-and-forget strobe and TxLoad is always accepted.
//
// Signals (direction seen from the slave modport):
//    TxData   in   DATA_WIDTH  word returned to the SPI master at the next word boundary
//    TxLoad   in   1           writes TxData into the transmit holding register this cycle
//    RxData   out  DATA_WIDTH  last complete received word
//    RxValid  out  1           one-cycle pulse when RxData updates
//    Busy     out  1           high while a transfer is in progress (target selected)
//    RxRead   in   1           host has consumed RxData        (SPI_SLAVE_OVERRUN_EN only)
//    Overrun  out  1           sticky: a word was lost unread  (SPI_SLAVE_OVERRUN_EN only)
// The optional pair is present only when the macro SPI_SLAVE_OVERRUN_EN is defined.

interface spi_slave_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] TxData;
   logic                  TxLoad;
   logic [DATA_WIDTH-1:0] RxData;
   logic                  RxValid;
   logic                  Busy;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic                  RxRead;
   logic                  Overrun;
`endif

   // The SPI target itself.
   modport slave (
      input  TxData,
      input  TxLoad,
`ifdef SPI_SLAVE_OVERRUN_EN
      input  RxRead,
      output Overrun,
`endif
      output RxData,
      output RxValid,
      output Busy
   );

   // The local host that feeds and drains the target.
   modport master (
      output TxData,
      output TxLoad,
`ifdef SPI_SLAVE_OVERRUN_EN
      output RxRead,
      input  Overrun,
`endif
      input  RxData,
      input  RxValid,
      input  Busy
   );
endinterface

// File: rtl/spi_slave.sv
// SPI target, modes 0-3, DATA_WIDTH-bit words MSB-first, pins oversampled by Clk.
// Latency: pin edge to internal action 3 Clk; RxData/RxValid registered on the Clk after the last sample.
// Backpressure: none on the SPI side; host loads TxHold at any time, received words are pulsed once.
//
// Ports:
//    Clk, Reset     system clock and synchronous active-high reset
//    MODE[1:0]      CPOL = MODE[1], CPHA = MODE[0]; captured when SS falls
//    host           spi_slave_if.slave: TxData/TxLoad in, RxData/RxValid/Busy out
//                   (plus RxRead/Overrun when SPI_SLAVE_OVERRUN_EN is defined)
//    SClk, SS, MOSI asynchronous SPI pins from the master
//    MISO, MisoOe   slave-out data and its pad enable
// Optional feature macro: SPI_SLAVE_OVERRUN_EN adds the RxRead/Overrun lost-word detection.

module spi_slave #(
   parameter int DATA_WIDTH = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] MODE,
   spi_slave_if.slave host,
   input  logic       SClk,
   input  logic       SS,
   input  logic       MOSI,
   output logic       MISO,
   output logic       MisoOe
);

   localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t state_q, state_d;

   // ------------------------------------------------------------------
   // Pin synchronizers. Index 0 is the first stage. SClk and SS carry a
   // third stage so edges are seen as stage[1] != stage[2].
   // ------------------------------------------------------------------
   logic [2:0] sclk_s;
   logic [2:0] ss_s;
   logic [1:0] mosi_s;

   // The SS synchronizer presets to "deselected". If the pin is already low
   // when Reset drops, the preset-to-pin transition would look like a fresh
   // falling edge and restart an aborted transfer. ss_armed only rises once
   // a genuinely sampled high level of SS has been seen after reset.
   logic sync_live_q;
   logic ss_armed_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sclk_s      <= 3'b000;
         ss_s        <= 3'b111;
         mosi_s      <= 2'b00;
         sync_live_q <= 1'b0;
         ss_armed_q  <= 1'b0;
      end else begin
         sclk_s      <= {sclk_s[1:0], SClk};
         ss_s        <= {ss_s[1:0], SS};
         mosi_s      <= {mosi_s[0], MOSI};
         sync_live_q <= 1'b1;
         if (sync_live_q && ss_s[0]) begin
            ss_armed_q <= 1'b1;
         end
      end
   end

   logic ss_fall, ss_rise;
   logic sclk_rise, sclk_fall;
   logic mosi_sync;

   assign ss_fall   = ss_armed_q & ~ss_s[1] &  ss_s[2];
   assign ss_rise   =  ss_s[1] & ~ss_s[2];
   assign sclk_rise =  sclk_s[1] & ~sclk_s[2];
   assign sclk_fall = ~sclk_s[1] &  sclk_s[2];
   assign mosi_sync =  mosi_s[1];

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] tx_hold_q;
   logic [DATA_WIDTH-1:0] tx_shift_q;
   logic [DATA_WIDTH-1:0] rx_shift_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic [CW-1:0]         bit_cnt_q;
   logic                  miso_q;
   // first_q: the next shift event must present tx_shift's MSB rather than
   // advance the shifter (start of every CPHA=1 word, and every word after
   // the first within one selection).
   logic                  first_q;

   logic cpol, cpha;
   logic lead_edge, trail_edge;
   logic sample_evt, shift_evt;
   logic last_bit;

   assign cpol       = mode_q[1];
   assign cpha       = mode_q[0];
   assign lead_edge  = cpol ? sclk_fall : sclk_rise;
   assign trail_edge = cpol ? sclk_rise : sclk_fall;

   // CPHA=0 samples on leading and shifts on trailing; CPHA=1 the reverse.
   assign sample_evt = (state_q == ACTIVE) && (cpha ? trail_edge : lead_edge);
   assign shift_evt  = (state_q == ACTIVE) && (cpha ? lead_edge  : trail_edge);
   assign last_bit   = (bit_cnt_q == CW'(DATA_WIDTH - 1));

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ss_fall) state_d = ACTIVE;
         ACTIVE:  if (ss_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   logic busy;

   always_comb begin
      busy   = 1'b0;
      MisoOe = 1'b0;
      MISO   = 1'b0;
      if (state_q == ACTIVE) begin
         busy   = 1'b1;
         MisoOe = 1'b1;
         MISO   = miso_q;
      end
   end

   // ------------------------------------------------------------------
   // Shift / count datapath
   // ------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         mode_q     <= 2'b00;
         tx_hold_q  <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         bit_cnt_q  <= '0;
         miso_q     <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;

         // Host may refill the holding register mid-word; the shifter only
         // picks it up at the next word boundary.
         if (host.TxLoad) begin
            tx_hold_q <= host.TxData;
         end

         case (state_q)
            IDLE: begin
               if (ss_fall) begin
                  mode_q     <= MODE;
                  tx_shift_q <= tx_hold_q;
                  bit_cnt_q  <= '0;
                  // CPHA=0 must present the MSB before the first leading
                  // edge; CPHA=1 presents it on that edge instead.
                  first_q    <= MODE[0];
                  miso_q     <= MODE[0] ? 1'b0 : tx_hold_q[DATA_WIDTH-1];
               end
            end

            ACTIVE: begin
               if (sample_evt) begin
                  rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                  if (last_bit) begin
                     rx_data_q  <= {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};
                     rx_valid_q <= 1'b1;
                     bit_cnt_q  <= '0;
                     tx_shift_q <= tx_hold_q;
                     first_q    <= 1'b1;
                  end else begin
                     bit_cnt_q  <= bit_cnt_q + CW'(1);
                  end
               end

               // Sample and shift events come from opposite SClk edges and
               // can never fall in the same Clk cycle.
               if (shift_evt) begin
                  if (first_q) begin
                     miso_q  <= tx_shift_q[DATA_WIDTH-1];
                     first_q <= 1'b0;
                  end else begin
                     miso_q     <= tx_shift_q[DATA_WIDTH-2];
                     tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                  end
               end

               // Deselect discards any partial word. A word whose final
               // sample lands in this same cycle has already been captured
               // above and still produces its RxValid.
               if (ss_rise) begin
                  bit_cnt_q <= '0;
                  miso_q    <= 1'b0;
                  first_q   <= 1'b0;
               end
            end

            default: ;
         endcase
      end
   end

   assign host.RxData  = rx_data_q;
   assign host.RxValid = rx_valid_q;
   assign host.Busy    = busy;

`ifdef SPI_SLAVE_OVERRUN_EN
   // ------------------------------------------------------------------
   // Lost-word detection: a new word arriving while the previous one is
   // still unread (and not being read this very cycle) flags Overrun.
   // A read coinciding with a new word leaves the new word pending.
   // ------------------------------------------------------------------
   logic rx_pending_q;
   logic overrun_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rx_pending_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if (rx_valid_q) begin
            rx_pending_q <= 1'b1;
         end else if (host.RxRead) begin
            rx_pending_q <= 1'b0;
         end
         if (rx_valid_q && rx_pending_q && !host.RxRead) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign host.Overrun = overrun_q;
`endif

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target-side peer to the team's SPI master. Oversamples SClk, SS and MOSI with system Clk, supports SPI modes 0-3, and shifts DATA_WIDTH-bit words MSB-first in both directions.
- Presents each received word with a one-cycle valid pulse and returns a host-loaded transmit word on MISO.
- Sits between the external SPI pins and a local register/FIFO interface.

Parameters:
- DATA_WIDTH, 8, word length in bits; must be >= 2.

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset  input  1  synchronous, active-high reset
- MODE  input  2  SPI mode; CPOL = MODE[1], CPHA = MODE[0]; latched at SS falling edge
- TxData  input  DATA_WIDTH  word to return to master
- TxLoad  input  1  writes TxData into TxHold this cycle
- RxData  output  DATA_WIDTH  last complete received word
- RxValid  output  1  one-Clk pulse when RxData updates
- Busy  output  1  high while synchronized SS is low
- SClk  input  1  SPI clock from master (asynchronous)
- SS  input  1  slave select, active low (asynchronous)
- MOSI  input  1  master-out data (asynchronous)
- MISO  output  1  slave-out data
- MisoOe  output  1  MISO output enable for the pad (high while selected)

Behaviour:
- Reset: all of the following clear to 0: RxData, RxValid, Busy, MISO, MisoOe, TxHold, shift registers and bit counter. FSM goes to IDLE. Synchronizer stages preset to idle values: SS = 1, SClk = 0.
- Synchronization: SClk, SS and MOSI each pass through 2 flops. SClk and SS get a third flop for edge detection. Pin-to-detected-edge latency is 3 Clk.
- Supported rate: SClk half-period >= 4 Clk, i.e. master ClkDiv >= 1. Faster SClk is unsupported and behaviour is undefined.
- TxHold: loaded from TxData on any TxLoad, including while Busy. The new value takes effect at the next word boundary.
- Edge definitions: leading edge = synced SClk leaves CPOL; trailing edge = synced SClk returns to CPOL.
- FSM IDLE:
  - MisoOe = 0, MISO = 0.
  - On SS falling: latch MODE, load TxShift from TxHold, clear bit counter, go to ACTIVE.
  - If CPHA = 0, MISO = TxHold[MSB] in the same cycle.
- FSM ACTIVE (Busy = 1, MisoOe = 1):
  - CPHA = 0: sample MOSI into RxShift on the leading edge; shift TxShift and drive the next bit on MISO on the trailing edge.
  - CPHA = 1: shift and drive on the leading edge (first leading edge drives the MSB); sample on the trailing edge.
  - Bit counter increments once per sample.
  - After the DATA_WIDTH-th sample:
    - RxData <= {RxShift[DATA_WIDTH-2:0], MOSI_sync} on the next Clk.
    - RxValid pulses 1 Clk.
    - Bit counter clears.
    - TxShift reloads from TxHold; for CPHA = 0 the new MSB is driven at the following trailing edge in place of a shift.
  - Back-to-back words under one SS-low period are supported.
- SS rising:
  - In any state, go to IDLE next cycle; Busy, MisoOe and MISO drop to 0.
  - A partial word (counter not 0) is discarded: no RxValid, RxData unchanged.
  - If the final sample and SS rising are detected in the same cycle, the word completes and RxValid fires.
- MODE changes while Busy are ignored until the next SS falling edge.
- Reset mid-transfer: immediate return to reset state. The transfer is aborted even if SS stays low; the FSM waits for a fresh SS falling edge.
- SClk edges while SS is high are ignored.

Optional Feature:
- SPI_SLAVE_OVERRUN_EN:
  - Adds input RxRead (1 bit) and output Overrun (1 bit).
  - An internal RxPending flag sets on RxValid and clears on RxRead. If RxValid and RxRead coincide, RxPending stays set.
  - Overrun sets when RxValid fires while RxPending = 1 and the same cycle's RxRead = 0.
  - Overrun is sticky until Reset. RxData is still overwritten.
- Without the macro: neither port exists and there is no pending/overrun logic.

Test Plan:
- Mode 0, DATA_WIDTH = 8, SClk = Clk/8, TxHold = 0xA5, master sends 0x3C → RxData = 0x3C with one RxValid pulse; master captures 0xA5 on MISO.
- Modes 1, 2 and 3 each exchange 0x96 / 0x69 → RxData = 0x96, master receives 0x69; MISO changes only on the mode-correct edge.
- SS held low for 2 words (0x11, 0x22), TxLoad 0x55 mid-first-word with TxHold initially 0xF0 → RxValid twice with 0x11 then 0x22; master receives 0xF0 then 0x55.
- SS raised after 5 bits → no RxValid, RxData keeps its previous value, Busy = 0 within 3 Clk; the next full word 0x81 is received correctly.
- Reset asserted at bit 4 with SS low → all outputs 0 next cycle; no RxValid until after a new SS falling edge.
- (SPI_SLAVE_OVERRUN_EN) 2 words received with no RxRead → Overrun = 1 after the second RxValid and stays set; RxRead in the second word's completion cycle → Overrun stays 0.
